// File: rtl/mmio_aict.sv
// Purpose: address-decoded interrupt controller table (AICT) overlaid on a CPU-to-SRAM bus, plus an edge-triggered priority interrupt requester.
// Latency: AICT reads/writes answer one cycle after valid; non-AICT accesses pass straight through to SRAM combinationally.
// Backpressure: CPU ready follows SRAM srdy outside the window; inside it ready pulses for the single ACK cycle; interrupt requests hold until iack.
//
// Ports:
//   clk, reset                         - clock, asynchronous active-high reset
//   valid/ready/addr/dtw/dtr/rw        - CPU bus (rw=1 write)
//   sval/srdy/saddr/sdtw/sdtr/srw      - SRAM bus (passthrough for addresses outside the AICT window)
//   interrupts/iack/handler/intrq/vec/nmi - interrupt lines in, request/vector/handler out, acknowledge in
module mmio_aict #(
  parameter int          NUM_IRQ         = 24,
  parameter logic [31:0] AICT_RESET_BASE = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  // CPU bus
  input  logic               valid,
  output logic               ready,
  input  logic [31:0]        addr,
  input  logic [31:0]        dtw,
  output logic [31:0]        dtr,
  input  logic               rw,
  // SRAM bus
  output logic               sval,
  input  logic               srdy,
  output logic [31:0]        saddr,
  output logic [31:0]        sdtw,
  input  logic [31:0]        sdtr,
  output logic               srw,
  // interrupt interface
  input  logic [NUM_IRQ-1:0] interrupts,
  input  logic               iack,
  output logic [31:0]        handler,
  output logic               intrq,
  output logic [4:0]         vec,
  output logic               nmi
);

  localparam int          NUM_ENT   = NUM_IRQ + 1;
  localparam logic [32:0] WIN_BYTES = 33'(NUM_ENT * 4);

  typedef enum logic {IDLE, ACK}     bus_state_t;
  typedef enum logic {I_IDLE, I_REQ} irq_state_t;

  // entry 0 is the window base, entry k is the handler for line k-1
  logic [31:0]        aict [NUM_ENT];
  logic [31:0]        rdata;
  bus_state_t         bus_state, bus_next;
  irq_state_t         irq_state, irq_next;
  logic [NUM_IRQ-1:0] irq_prev, pending, pending_next, irq_edge, enabled, eligible;
  logic [4:0]         vec_q, vec_next, ent_idx;
  logic [32:0]        win_end;
  logic [31:0]        rd_mux, hnd_mux;
  logic               hit, bus_take;

  // 33-bit end address: a window running past 2^32 simply covers up to 32'hFFFF_FFFF
  assign win_end = {1'b0, aict[0]} + WIN_BYTES;
  assign hit     = (addr >= aict[0]) && ({1'b0, addr} < win_end);
  assign ent_idx = 5'((addr - aict[0]) >> 2);

  // table read ports: one for the CPU access, one for the live handler of the latched vector
  always_comb begin
    rd_mux  = '0;
    hnd_mux = '0;
    for (int k = 0; k < NUM_ENT; k++) begin
      if (ent_idx == 5'(k)) rd_mux = aict[k];
      if (({1'b0, vec_q} + 6'd1) == 6'(k)) hnd_mux = aict[k];
    end
  end

  // ---------------- bus FSM ----------------
  always_comb begin
    bus_next = bus_state;
    bus_take = 1'b0;
    case (bus_state)
      IDLE: begin
        if (valid && hit) begin
          bus_next = ACK;
          bus_take = 1'b1;
        end
      end
      ACK:     bus_next = IDLE;
      default: bus_next = IDLE;
    endcase
  end

  assign sval  = valid && !hit && (bus_state == IDLE);
  assign saddr = addr;
  assign sdtw  = dtw;
  assign srw   = rw;
  // during ACK the answer is ours regardless of where the (possibly moved) window now sits
  assign ready = (bus_state == ACK) || (!hit && srdy);
  assign dtr   = (bus_state == ACK) ? rdata : sdtr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_state <= IDLE;
      rdata     <= '0;
      aict[0]   <= AICT_RESET_BASE;
      for (int k = 1; k < NUM_ENT; k++) aict[k] <= '0;
    end else begin
      bus_state <= bus_next;
      if (bus_take) begin
        if (rw) begin
          for (int k = 0; k < NUM_ENT; k++) begin
            if (ent_idx == 5'(k)) aict[k] <= dtw;
          end
        end else begin
          rdata <= rd_mux;
        end
      end
    end
  end

  // ---------------- interrupt FSM ----------------
  assign irq_edge = interrupts & ~irq_prev;

  // line 0 is non-maskable; other lines are gated by a nonzero handler
  always_comb begin
    enabled    = '0;
    enabled[0] = 1'b1;
    for (int i = 1; i < NUM_IRQ; i++) enabled[i] = |aict[i+1];
  end

  assign eligible = pending & enabled;

  always_comb begin
    irq_next     = irq_state;
    vec_next     = vec_q;
    pending_next = pending | irq_edge;
    case (irq_state)
      I_IDLE: begin
        if (|eligible) begin
          irq_next = I_REQ;
          for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) vec_next = 5'(i);
          end
        end
      end
      I_REQ: begin
        if (iack) begin
          irq_next = I_IDLE;
          // a fresh edge on the acknowledged line in the same cycle keeps it pending
          for (int i = 0; i < NUM_IRQ; i++) begin
            if (vec_q == 5'(i)) pending_next[i] = irq_edge[i];
          end
        end
      end
      default: irq_next = I_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_state <= I_IDLE;
      irq_prev  <= '0;
      pending   <= '0;
      vec_q     <= '0;
    end else begin
      irq_state <= irq_next;
      irq_prev  <= interrupts;
      pending   <= pending_next;
      vec_q     <= vec_next;
    end
  end

  assign intrq   = (irq_state == I_REQ);
  assign nmi     = (irq_state == I_REQ) && (vec_q == 5'd0);
  assign vec     = vec_q;
  assign handler = hnd_mux;

endmodule

// File: doc/mmio_aict.md
MMIO_AICT -- requirements
Module: mmio_aict

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 24, giving the number of interrupt lines (legal range 1..31).
REQ-002 SHALL have parameter AICT_RESET_BASE, default 32'h0000_0000, giving the AICT window base loaded at reset.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports valid in 1, ready out 1, addr in 32, dtw in 32, dtr out 32, rw in 1, forming the CPU bus; rw=1 means write.
REQ-006 SHALL have ports sval out 1, srdy in 1, saddr out 32, sdtw out 32, sdtr in 32, srw out 1, forming the SRAM bus.
REQ-007 SHALL have ports interrupts in NUM_IRQ, iack in 1, handler out 32, intrq out 1, vec out 5, nmi out 1, forming the interrupt interface.

Function
REQ-008 SHALL hold AICT as NUM_IRQ+1 32-bit entries: entry 0 = window base; entry k (1..NUM_IRQ) = handler for line k-1.
REQ-009 SHALL decode hit = (entry0 <= addr) && (addr < entry0 + (NUM_IRQ+1)*4), 32-bit unsigned compare, no wrap-around; a window that overflows 2^32 is truncated at 32'hFFFF_FFFF.
REQ-010 SHALL index the entry as (addr - entry0) >> 2; addr[1:0] ignored.
REQ-011 SHALL route non-hit accesses combinationally: sval = valid && !hit && bus FSM in IDLE; saddr=addr, sdtw=dtw, srw=rw; ready=srdy, dtr=sdtr.
REQ-012 SHALL run a bus FSM with states IDLE and ACK; IDLE->ACK on valid && hit; ACK->IDLE unconditionally after one cycle.
REQ-013 SHALL, on the IDLE->ACK edge, register the indexed entry into a read-data register (reads) or write dtw into the indexed entry (writes).
REQ-014 SHALL assert ready for exactly the one ACK cycle of an AICT access, with dtr = read-data register; latency 1 cycle for reads and writes alike.
REQ-015 SHALL make a write to entry 0 move the window starting in the cycle after ACK; the ACK cycle itself still completes.
REQ-016 SHALL ignore valid during ACK; the master deasserts or re-presents valid after ready.
REQ-017 SHALL detect rising edges on each interrupts bit using a registered previous-value copy, setting pending[i].
REQ-018 SHALL treat line 0 as non-maskable; line i>0 is enabled only while its handler entry is nonzero (pending still latches while disabled).
REQ-019 SHALL run an interrupt FSM with states I_IDLE and I_REQ; I_IDLE->I_REQ when any enabled pending bit exists, latching vec = lowest such index.
REQ-020 SHALL drive, in I_REQ, intrq=1, handler=entry vec+1 (live value), nmi=(vec==0); in I_IDLE intrq=0, nmi=0, vec and handler hold last value.
REQ-021 SHALL, on iack in I_REQ, clear pending[vec] and return to I_IDLE; iack in I_IDLE is ignored.
REQ-022 SHALL give a new edge on line vec in the same cycle as iack priority: pending[vec] stays set.
REQ-023 SHALL keep I_REQ and the latched vec if the handler entry is cleared while requesting; a higher-priority arrival does not preempt a latched request.

Reset
REQ-024 SHALL, on reset, asynchronously set entry0=AICT_RESET_BASE, all other entries=0, pending=0, edge-history=0, bus FSM=IDLE, interrupt FSM=I_IDLE, read-data=0, vec=0.
REQ-025 SHALL give output values under reset: intrq=0, nmi=0, handler=entry 1 value (0), vec=0; ready and dtr follow SRAM passthrough (srdy, sdtr) when not hit.
REQ-026 SHALL, on reset mid-transaction, abort any AICT or interrupt handshake with no entry modified after reset asserts.

Verification
REQ-027 SHALL cover: base=0x1000, write 0x2000 to 0x1004 then read 0x1004 -> ready one cycle after each valid, dtr=0x2000, sval stays 0.
REQ-028 SHALL cover: read 0x1064 (NUM_IRQ=24, past window) -> sval=1, ready=srdy, dtr=sdtr; 0x1060 -> AICT entry 24.
REQ-029 SHALL cover: write 0x8000 to 0x1000, then access 0x1000 -> SRAM path; access 0x8000 -> entry 0 reads 0x8000.
REQ-030 SHALL cover: entry 4=0x4000, pulse interrupts[3] and [5] together (entry 6=0) -> intrq, vec=3, handler=0x4000; iack -> intrq drops, line 5 never requested.
REQ-031 SHALL cover: pulse line 0 with all handlers 0 -> intrq=1, nmi=1, vec=0; iack with simultaneous new edge on line 0 -> request reasserts next cycle.
REQ-032 SHALL cover: assert reset during AICT write ACK and during I_REQ -> all state at REQ-024 values, intrq=0 within the reset cycle.
